// File: rtl/cam_line_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// cam_line_pingpong_ctrl
//
// Capture-side controller for a parallel camera port. Samples CamVSYNC / HREF /
// PixData on CamPCLK, packs byte pairs into 16-bit RGB565 pixels and writes
// whole lines alternately into two line buffers (ping-pong). Tracks per-buffer
// ownership (FREE / FILLING / FULL) against the downstream consumer and issues
// buffer clear pulses when a buffer is released, abandoned or aborted.
//
// Ports
//   CamPCLK      in   camera pixel clock, all logic on its rising edge
//   reset        in   synchronous active-high reset
//   CamVSYNC     in   frame sync, high during vertical blank
//   HREF         in   line valid
//   PixData      in   camera byte (valid while HREF=1)
//   readDone     in   bit n: consumer finished with buffer n+1 (pulse)
//   pixOutput    out  packed pixel {first byte, second byte}
//   pixAddr      out  pixel index within the line for the current write
//   writeBuff1/2 out  write strobe to buffer 1 / 2
//   buffClear1/2 out  clear pulse to buffer 1 / 2
//   lineReady    out  pulse: a full line has been committed
//   lineBuf      out  committed buffer (0 = buffer 1, 1 = buffer 2)
//   lineNum      out  line index within the frame, valid with lineReady
//   frameStart   out  pulse on the CamVSYNC falling edge
//   overrun      out  sticky: a line was dropped (target buffer not free)
//   shortLine    out  sticky: a line ended before 2*LINE_PIXELS bytes
// -----------------------------------------------------------------------------
module cam_line_pingpong_ctrl #(
  parameter int LINE_PIXELS = 640,
  parameter int ADDR_W      = 10
) (
  input  logic              CamPCLK,
  input  logic              reset,
  input  logic              CamVSYNC,
  input  logic              HREF,
  input  logic [7:0]        PixData,
  input  logic [1:0]        readDone,
  output logic [15:0]       pixOutput,
  output logic [ADDR_W-1:0] pixAddr,
  output logic              writeBuff1,
  output logic              writeBuff2,
  output logic              buffClear1,
  output logic              buffClear2,
  output logic              lineReady,
  output logic              lineBuf,
  output logic [8:0]        lineNum,
  output logic              frameStart,
  output logic              overrun,
  output logic              shortLine
);

  // Byte counter needs to hold the value 2*LINE_PIXELS itself (it saturates
  // there), which can be 2^(ADDR_W+1).
  localparam int                CNT_W      = ADDR_W + 2;
  localparam logic [CNT_W-1:0]  LINE_BYTES = CNT_W'(2 * LINE_PIXELS);

  typedef enum logic [1:0] {S_SYNC, S_WAIT_LINE, S_CAPTURE, S_DROP} state_e;
  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL} bstate_e;

  state_e            state_q, state_d;
  bstate_e           bstate_q [2];
  bstate_e           bstate_d [2];
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic              next_buf_q, next_buf_d;
  logic              cur_buf_q, cur_buf_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]        hi_q, hi_d;
  logic [8:0]        line_cnt_q, line_cnt_d;
  logic [15:0]       pix_out_q, pix_out_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [1:0]        wr_q, wr_d;
  logic [1:0]        clr_q, clr_d;
  logic              line_ready_q, line_ready_d;
  logic              line_buf_q, line_buf_d;
  logic [8:0]        line_num_q, line_num_d;
  logic              frame_start_q, frame_start_d;
  logic              overrun_q, overrun_d;
  logic              short_line_q, short_line_d;

  logic vsync_rise, vsync_fall, href_rise, href_fall;
  logic [8:0] line_cnt_inc;

  assign vsync_rise   = CamVSYNC & ~vsync_q;
  assign vsync_fall   = ~CamVSYNC & vsync_q;
  assign href_rise    = HREF & ~href_q;
  assign href_fall    = ~HREF & href_q;
  assign line_cnt_inc = (line_cnt_q == 9'd511) ? line_cnt_q : line_cnt_q + 9'd1;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    state_d       = state_q;
    bstate_d      = bstate_q;
    vsync_d       = CamVSYNC;
    href_d        = HREF;
    next_buf_d    = next_buf_q;
    cur_buf_d     = cur_buf_q;
    byte_cnt_d    = byte_cnt_q;
    hi_d          = hi_q;
    line_cnt_d    = line_cnt_q;
    pix_out_d     = pix_out_q;
    pix_addr_d    = pix_addr_q;
    wr_d          = 2'b00;
    clr_d         = 2'b00;
    line_ready_d  = 1'b0;
    line_buf_d    = line_buf_q;
    line_num_d    = line_num_q;
    frame_start_d = 1'b0;
    overrun_d     = overrun_q;
    short_line_d  = short_line_q;

    // Consumer releases are applied first so that a release arriving with the
    // HREF rise is already visible to the buffer-availability test below.
    for (int i = 0; i < 2; i++) begin
      if (readDone[i] && bstate_q[i] == B_FULL) begin
        bstate_d[i] = B_FREE;
        clr_d[i]    = 1'b1;
      end
    end

    case (state_q)
      S_SYNC: ;

      S_WAIT_LINE: begin
        if (href_rise) begin
          if (bstate_d[next_buf_q] == B_FREE) begin
            bstate_d[next_buf_q] = B_FILLING;
            cur_buf_d            = next_buf_q;
            hi_d                 = PixData;   // the rise cycle carries byte 0
            byte_cnt_d           = CNT_W'(1);
            state_d              = S_CAPTURE;
          end else begin
            overrun_d = 1'b1;
            state_d   = S_DROP;
          end
        end
      end

      S_CAPTURE: begin
        if (vsync_rise) begin
          // Frame abort: the partial line is discarded. No write is issued in
          // this cycle so the clear never coincides with a strobe.
          bstate_d[cur_buf_q] = B_FREE;
          clr_d[cur_buf_q]    = 1'b1;
          state_d             = S_WAIT_LINE;
        end else if (HREF) begin
          if (!byte_cnt_q[0]) begin
            hi_d = PixData;
          end else if (byte_cnt_q < LINE_BYTES) begin
            wr_d[cur_buf_q] = 1'b1;
            pix_out_d       = {hi_q, PixData};
            pix_addr_d      = byte_cnt_q[ADDR_W:1];
          end
          if (byte_cnt_q != LINE_BYTES) byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end else if (href_fall) begin
          if (byte_cnt_q >= LINE_BYTES) begin
            bstate_d[cur_buf_q] = B_FULL;
            line_ready_d        = 1'b1;
            line_buf_d          = cur_buf_q;
            line_num_d          = line_cnt_q;
            next_buf_d          = ~next_buf_q;
          end else begin
            // Short line: give the buffer back and retry the same buffer.
            short_line_d        = 1'b1;
            bstate_d[cur_buf_q] = B_FREE;
            clr_d[cur_buf_q]    = 1'b1;
          end
          line_cnt_d = line_cnt_inc;
          state_d    = S_WAIT_LINE;
        end
      end

      S_DROP: begin
        if (vsync_rise) begin
          state_d = S_WAIT_LINE;
        end else if (href_fall) begin
          // Keep the ping-pong phase aligned with the line count.
          line_cnt_d = line_cnt_inc;
          next_buf_d = ~next_buf_q;
          state_d    = S_WAIT_LINE;
        end
      end

      default: state_d = S_SYNC;
    endcase

    // New frame: restart numbering and the ping-pong sequence at buffer 1.
    if (vsync_fall) begin
      frame_start_d = 1'b1;
      line_cnt_d    = 9'd0;
      next_buf_d    = 1'b0;
      if (state_q == S_SYNC) state_d = S_WAIT_LINE;
    end
  end

  always_ff @(posedge CamPCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q       <= S_SYNC;
      bstate_q[0]   <= B_FREE;
      bstate_q[1]   <= B_FREE;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      next_buf_q    <= 1'b0;
      cur_buf_q     <= 1'b0;
      byte_cnt_q    <= '0;
      hi_q          <= 8'd0;
      line_cnt_q    <= 9'd0;
      pix_out_q     <= 16'd0;
      pix_addr_q    <= '0;
      wr_q          <= 2'b00;
      clr_q         <= 2'b00;
      line_ready_q  <= 1'b0;
      line_buf_q    <= 1'b0;
      line_num_q    <= 9'd0;
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
      short_line_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      bstate_q      <= bstate_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      next_buf_q    <= next_buf_d;
      cur_buf_q     <= cur_buf_d;
      byte_cnt_q    <= byte_cnt_d;
      hi_q          <= hi_d;
      line_cnt_q    <= line_cnt_d;
      pix_out_q     <= pix_out_d;
      pix_addr_q    <= pix_addr_d;
      wr_q          <= wr_d;
      clr_q         <= clr_d;
      line_ready_q  <= line_ready_d;
      line_buf_q    <= line_buf_d;
      line_num_q    <= line_num_d;
      frame_start_q <= frame_start_d;
      overrun_q     <= overrun_d;
      short_line_q  <= short_line_d;
    end
  end

  assign pixOutput  = pix_out_q;
  assign pixAddr    = pix_addr_q;
  assign writeBuff1 = wr_q[0];
  assign writeBuff2 = wr_q[1];
  assign buffClear1 = clr_q[0];
  assign buffClear2 = clr_q[1];
  assign lineReady  = line_ready_q;
  assign lineBuf    = line_buf_q;
  assign lineNum    = line_num_q;
  assign frameStart = frame_start_q;
  assign overrun    = overrun_q;
  assign shortLine  = short_line_q;

endmodule

// File: tb/tb_cam_line_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cam_line_pingpong_ctrl
//
// Directed bench for cam_line_pingpong_ctrl with default parameters
// (640 pixels / 1280 bytes per line). A negedge monitor collects writes,
// clears, frame starts and committed lines; directed scenarios then compare
// the collected results against hand-derived expected values.
// -----------------------------------------------------------------------------
module tb_cam_line_pingpong_ctrl;

  localparam int LP = 640;
  localparam int LB = 2 * LP;

  logic        clk;
  logic        reset;
  logic        CamVSYNC;
  logic        HREF;
  logic [7:0]  PixData;
  logic [1:0]  readDone;
  logic [15:0] pixOutput;
  logic [9:0]  pixAddr;
  logic        writeBuff1, writeBuff2;
  logic        buffClear1, buffClear2;
  logic        lineReady;
  logic        lineBuf;
  logic [8:0]  lineNum;
  logic        frameStart;
  logic        overrun;
  logic        shortLine;

  cam_line_pingpong_ctrl #(.LINE_PIXELS(LP), .ADDR_W(10)) dut (
    .CamPCLK    (clk),
    .reset      (reset),
    .CamVSYNC   (CamVSYNC),
    .HREF       (HREF),
    .PixData    (PixData),
    .readDone   (readDone),
    .pixOutput  (pixOutput),
    .pixAddr    (pixAddr),
    .writeBuff1 (writeBuff1),
    .writeBuff2 (writeBuff2),
    .buffClear1 (buffClear1),
    .buffClear2 (buffClear2),
    .lineReady  (lineReady),
    .lineBuf    (lineBuf),
    .lineNum    (lineNum),
    .frameStart (frameStart),
    .overrun    (overrun),
    .shortLine  (shortLine)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checking
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  typedef struct {
    int bufn;
    int num;
    int first;
    int last;
    int last_addr;
    int nwr;
  } line_rec_t;

  line_rec_t line_q[$];
  int cur_first, cur_last, cur_last_addr, cur_nwr;
  int wr_cnt[2];
  int clr_cnt[2];
  int fs_cnt;
  int conflict_cnt = 0;
  logic auto_rd;

  always @(negedge clk) begin
    if (writeBuff1 || writeBuff2) begin
      if (pixAddr == 10'd0) cur_first = int'(pixOutput);
      cur_last      = int'(pixOutput);
      cur_last_addr = int'(pixAddr);
      cur_nwr++;
      if (writeBuff1) wr_cnt[0]++;
      if (writeBuff2) wr_cnt[1]++;
    end
    if (buffClear1) clr_cnt[0]++;
    if (buffClear2) clr_cnt[1]++;
    if (frameStart) fs_cnt++;
    if ((writeBuff1 && buffClear1) || (writeBuff2 && buffClear2) ||
        (writeBuff1 && writeBuff2) || (lineReady && (writeBuff1 || writeBuff2)))
      conflict_cnt++;
    if (lineReady) begin
      line_q.push_back('{int'(lineBuf), int'(lineNum), cur_first, cur_last,
                         cur_last_addr, cur_nwr});
      cur_nwr   = 0;
      cur_first = -1;
    end
  end

  // Consumer model: release the committed buffer 10 cycles after lineReady.
  initial begin
    int rb;
    forever begin
      @(negedge clk);
      if (auto_rd && lineReady) begin
        rb = int'(lineBuf);
        repeat (10) @(posedge clk);
        #1 readDone[rb] = 1'b1;
        @(posedge clk);
        #1 readDone = 2'b00;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    line_q.delete();
    cur_first     = -1;
    cur_last      = -1;
    cur_last_addr = -1;
    cur_nwr       = 0;
    wr_cnt[0]     = 0;
    wr_cnt[1]     = 0;
    clr_cnt[0]    = 0;
    clr_cnt[1]    = 0;
    fs_cnt        = 0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    CamVSYNC = 1'b0;
    HREF     = 1'b0;
    PixData  = 8'd0;
    readDone = 2'b00;
    repeat (3) tick();
    reset = 1'b0;
    clear_stats();
    tick();
  endtask

  task automatic vsync_pulse();
    CamVSYNC = 1'b1;
    repeat (3) tick();
    CamVSYNC = 1'b0;
    repeat (3) tick();
  endtask

  // One line of nbytes bytes (PixData = byte index), then gap low cycles.
  // rd_first is driven on readDone together with the first byte.
  task automatic send_line(input int nbytes, input int gap, input logic [1:0] rd_first);
    for (int i = 0; i < nbytes; i++) begin
      HREF    = 1'b1;
      PixData = i[7:0];
      if (i == 0 && rd_first != 2'b00) readDone = rd_first;
      tick();
      if (i == 0 && rd_first != 2'b00) readDone = 2'b00;
    end
    HREF    = 1'b0;
    PixData = 8'd0;
    repeat (gap) tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    auto_rd = 1'b0;

    // ---- reset values
    do_reset();
    check("rst_pixOutput", pixOutput, 16'h0000);
    check("rst_pixAddr",   pixAddr, 10'd0);
    check("rst_strobes",   {writeBuff1, writeBuff2, buffClear1, buffClear2,
                            lineReady, frameStart}, 6'b0);
    check("rst_lineBuf",   lineBuf, 1'b0);
    check("rst_lineNum",   lineNum, 9'd0);
    check("rst_sticky",    {overrun, shortLine}, 2'b00);

    // ---- standard frame, 6 lines, consumer releasing each line
    auto_rd = 1'b1;
    vsync_pulse();
    check("std_frameStart", fs_cnt, 1);
    for (int l = 0; l < 6; l++) send_line(LB, 3, 2'b00);
    repeat (20) tick();
    check("std_lines", line_q.size(), 6);
    foreach (line_q[k]) begin
      check($sformatf("std_buf%0d", k),   line_q[k].bufn, k % 2);
      check($sformatf("std_num%0d", k),   line_q[k].num, k);
      check($sformatf("std_first%0d", k), line_q[k].first, 32'h0001);
      check($sformatf("std_last%0d", k),  line_q[k].last, 32'hFEFF);
      check($sformatf("std_laddr%0d", k), line_q[k].last_addr, 639);
      check($sformatf("std_nwr%0d", k),   line_q[k].nwr, LP);
    end
    check("std_clr1", clr_cnt[0], 3);
    check("std_clr2", clr_cnt[1], 3);
    check("std_overrun", overrun, 1'b0);

    // ---- consumer never releases
    auto_rd = 1'b0;
    do_reset();
    vsync_pulse();
    for (int l = 0; l < 4; l++) send_line(LB, 3, 2'b00);
    repeat (5) tick();
    check("ovr_lines", line_q.size(), 2);
    check("ovr_num1", line_q[1].num, 1);
    check("ovr_buf1", line_q[1].bufn, 1);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_writes", wr_cnt[0] + wr_cnt[1], LB);
    readDone = 2'b11;
    tick();
    readDone = 2'b00;
    repeat (3) tick();
    check("ovr_rel_clr", {clr_cnt[1][3:0], clr_cnt[0][3:0]}, 8'h11);
    send_line(LB, 3, 2'b00);
    check("ovr_after_lines", line_q.size(), 3);
    check("ovr_after_num", line_q[2].num, 4);
    check("ovr_after_buf", line_q[2].bufn, 0);

    // ---- short line of 1000 bytes
    auto_rd = 1'b1;
    do_reset();
    vsync_pulse();
    send_line(1000, 3, 2'b00);
    repeat (3) tick();
    check("short_writes", wr_cnt[0], 500);
    check("short_writes2", wr_cnt[1], 0);
    check("short_flag", shortLine, 1'b1);
    check("short_clr1", clr_cnt[0], 1);
    check("short_nolr", line_q.size(), 0);
    clear_stats();
    send_line(LB, 3, 2'b00);
    check("short_next_lines", line_q.size(), 1);
    check("short_next_buf", line_q[0].bufn, 0);
    check("short_next_num", line_q[0].num, 1);
    check("short_overrun", overrun, 1'b0);

    // ---- VSYNC asserted mid-line
    do_reset();
    vsync_pulse();
    send_line(LB, 3, 2'b00);
    for (int i = 0; i < 100; i++) begin
      HREF    = 1'b1;
      PixData = i[7:0];
      tick();
    end
    CamVSYNC = 1'b1;
    tick();
    HREF = 1'b0;
    repeat (3) tick();
    CamVSYNC = 1'b0;
    repeat (3) tick();
    check("abort_wr2", wr_cnt[1], 50);
    check("abort_clr2", clr_cnt[1], 1);
    check("abort_clr1", clr_cnt[0], 1);
    check("abort_lines", line_q.size(), 1);
    check("abort_fs", fs_cnt, 2);
    clear_stats();
    send_line(LB, 3, 2'b00);
    check("abort_next_buf", line_q[0].bufn, 0);
    check("abort_next_num", line_q[0].num, 0);

    // ---- reset released mid-line with HREF active
    auto_rd = 1'b0;
    do_reset();
    vsync_pulse();
    for (int i = 0; i < 200; i++) begin
      HREF    = 1'b1;
      PixData = i[7:0];
      tick();
    end
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_stats();
    for (int i = 0; i < 300; i++) begin
      PixData = i[7:0];
      tick();
    end
    HREF = 1'b0;
    repeat (3) tick();
    send_line(LB, 3, 2'b00);
    check("midrst_writes", wr_cnt[0] + wr_cnt[1], 0);
    check("midrst_lines", line_q.size(), 0);
    vsync_pulse();
    send_line(LB, 3, 2'b00);
    check("midrst_fs", fs_cnt, 1);
    check("midrst_lines2", line_q.size(), 1);
    check("midrst_buf", line_q[0].bufn, 0);
    check("midrst_nwr", line_q[0].nwr, LP);

    // ---- release in the same cycle as the HREF rise
    do_reset();
    vsync_pulse();
    send_line(LB, 3, 2'b00);
    send_line(LB, 3, 2'b00);
    send_line(LB, 3, 2'b01);
    repeat (3) tick();
    check("samecyc_lines", line_q.size(), 3);
    check("samecyc_buf", line_q[2].bufn, 0);
    check("samecyc_num", line_q[2].num, 2);
    check("samecyc_nwr", line_q[2].nwr, LP);
    check("samecyc_overrun", overrun, 1'b0);
    check("samecyc_clr1", clr_cnt[0], 1);

    // ---- lineNum saturation with minimum-gap short lines
    auto_rd = 1'b1;
    do_reset();
    vsync_pulse();
    for (int l = 0; l < 520; l++) send_line(2, 2, 2'b00);
    check("sat_short_clr", clr_cnt[0], 520);
    check("sat_short_wr", wr_cnt[0], 520);
    clear_stats();
    send_line(LB, 3, 2'b00);
    check("sat_num", line_q[0].num, 511);
    check("sat_buf", line_q[0].bufn, 0);
    check("sat_flag", shortLine, 1'b1);

    check("no_conflicts", conflict_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
